// File: rtl/cavlc_block_sequencer.sv
// cavlc_block_sequencer
//   Top-level sequencer for one CAVLC residual block. Steps through the
//   coeff_token -> level -> total_zeros -> run_before stage decoders, enabling
//   exactly one at a time. Latches the TotalCoeff/TrailingOnes/TotalZeros
//   results that the later stages consume. Muxes the active stage's shift
//   request onto the single shared bitstream barrel shifter.
//
// Ports
//   Clk, Reset                  clock; synchronous active-high reset
//   Start, Abort                block control from the slice/MB parser
//   MaxNumCoeff[4:0]            block size (4, 15 or 16), captured with Start
//   Ct*/Lv*/Tz*/Rb*             per-stage Done, results and shift requests
//   CtEnable..RbEnable          one-hot stage enables (state-decoded)
//   TotalCoeff, TrailingOnes,
//   TotalZeros                  latched stage results
//   NumShift, ShiftEn           shared barrel shifter request
//   Busy, BlockDone, Error      status (BlockDone is a 1-cycle pulse,
//                               Error stays high while parked in ERR)

module cavlc_block_sequencer #(
  parameter int WATCHDOG_CYCLES = 64,
  parameter int WD_W            = 7
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Abort,
  input  logic [4:0] MaxNumCoeff,
  input  logic       CtDone,
  input  logic [4:0] CtTotalCoeff,
  input  logic [1:0] CtTrailingOnes,
  input  logic [4:0] CtNumShift,
  input  logic       CtShiftEn,
  input  logic       LvDone,
  input  logic [4:0] LvNumShift,
  input  logic       LvShiftEn,
  input  logic       TzDone,
  input  logic [3:0] TzTotalZeros,
  input  logic [4:0] TzNumShift,
  input  logic       TzShiftEn,
  input  logic       RbDone,
  input  logic [4:0] RbNumShift,
  input  logic       RbShiftEn,
  output logic       CtEnable,
  output logic       LvEnable,
  output logic       TzEnable,
  output logic       RbEnable,
  output logic [4:0] TotalCoeff,
  output logic [1:0] TrailingOnes,
  output logic [3:0] TotalZeros,
  output logic [4:0] NumShift,
  output logic       ShiftEn,
  output logic       Busy,
  output logic       BlockDone,
  output logic       Error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CT,
    ST_LV,
    ST_TZ,
    ST_RB,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      tc_q, tc_d;
  logic [1:0]      t1_q, t1_d;
  logic [3:0]      tz_q, tz_d;
  logic [4:0]      max_q, max_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic in_stage;
  logic wd_expired;

  assign in_stage   = (state_q == ST_CT) || (state_q == ST_LV) ||
                      (state_q == ST_TZ) || (state_q == ST_RB);
  assign wd_expired = (wd_q == WD_W'(WATCHDOG_CYCLES - 1));

  // Next-state and result-latch logic. A stage's Done always takes priority
  // over a watchdog expiry in the same cycle; Abort overrides everything but
  // leaves the latched results untouched.
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    t1_d    = t1_q;
    tz_d    = tz_q;
    max_d   = max_q;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (Start) begin
          state_d = ST_CT;
          max_d   = MaxNumCoeff;
        end
      end
      ST_CT: begin
        if (CtDone) begin
          tc_d = CtTotalCoeff;
          t1_d = CtTrailingOnes;
          if (CtTotalCoeff == 5'd0)
            state_d = ST_DONE;
          else if (CtTotalCoeff > max_q)
            state_d = ST_ERR;
          else
            state_d = ST_LV;
        end else if (wd_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_LV: begin
        if (LvDone)
          state_d = (tc_q == max_q) ? ST_DONE : ST_TZ;
        else if (wd_expired)
          state_d = ST_ERR;
      end
      ST_TZ: begin
        if (TzDone) begin
          tz_d = TzTotalZeros;
          // No zeros left to place, or a single coefficient: run_before is empty.
          if ((TzTotalZeros == 4'd0) || (tc_q == 5'd1))
            state_d = ST_DONE;
          else
            state_d = ST_RB;
        end else if (wd_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_RB: begin
        if (RbDone)
          state_d = ST_DONE;
        else if (wd_expired)
          state_d = ST_ERR;
      end
      // DONE always lasts one cycle so every stage sees Enable low between
      // blocks and can clear its internal counters.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (Abort) begin
      state_d = ST_IDLE;
      tc_d    = tc_q;
      t1_d    = t1_q;
      tz_d    = tz_q;
      max_d   = max_q;
    end
  end

  // Watchdog restarts on every state change and only counts inside a stage.
  always_comb begin
    wd_d = '0;
    if ((state_d == state_q) && in_stage)
      wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      tc_q    <= '0;
      t1_q    <= '0;
      tz_q    <= '0;
      max_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      t1_q    <= t1_d;
      tz_q    <= tz_d;
      max_q   <= max_d;
      wd_q    <= wd_d;
    end
  end

  // Shared barrel shifter: only the active stage may drive it.
  always_comb begin
    NumShift = '0;
    ShiftEn  = 1'b0;
    case (state_q)
      ST_CT: begin
        NumShift = CtNumShift;
        ShiftEn  = CtShiftEn;
      end
      ST_LV: begin
        NumShift = LvNumShift;
        ShiftEn  = LvShiftEn;
      end
      ST_TZ: begin
        NumShift = TzNumShift;
        ShiftEn  = TzShiftEn;
      end
      ST_RB: begin
        NumShift = RbNumShift;
        ShiftEn  = RbShiftEn;
      end
      default: begin
        NumShift = '0;
        ShiftEn  = 1'b0;
      end
    endcase
  end

  assign CtEnable     = (state_q == ST_CT);
  assign LvEnable     = (state_q == ST_LV);
  assign TzEnable     = (state_q == ST_TZ);
  assign RbEnable     = (state_q == ST_RB);
  assign Busy         = in_stage || (state_q == ST_DONE);
  assign BlockDone    = (state_q == ST_DONE);
  assign Error        = (state_q == ST_ERR);
  assign TotalCoeff   = tc_q;
  assign TrailingOnes = t1_q;
  assign TotalZeros   = tz_q;

endmodule

// File: tb/tb_cavlc_block_sequencer.sv
// tb_cavlc_block_sequencer
//   Randomized bench for cavlc_block_sequencer. For each block the expected
//   list of visited stages is worked out up front from TotalCoeff,
//   MaxNumCoeff and TotalZeros, then walked cycle by cycle while the bench
//   drives Done on the chosen cycle, random shift requests, spurious Done
//   pulses from idle stages and stray Start pulses while busy.

module tb_cavlc_block_sequencer;

  localparam int S_IDLE = 0;
  localparam int S_CT   = 1;
  localparam int S_LV   = 2;
  localparam int S_TZ   = 3;
  localparam int S_RB   = 4;
  localparam int S_DONE = 5;
  localparam int S_ERR  = 6;
  localparam int WD     = 64;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0, Abort = 1'b0;
  logic [4:0] MaxNumCoeff = '0;
  logic       CtDone = 1'b0, LvDone = 1'b0, TzDone = 1'b0, RbDone = 1'b0;
  logic [4:0] CtTotalCoeff = '0;
  logic [1:0] CtTrailingOnes = '0;
  logic [3:0] TzTotalZeros = '0;
  logic [4:0] CtNumShift = '0, LvNumShift = '0, TzNumShift = '0, RbNumShift = '0;
  logic       CtShiftEn = 1'b0, LvShiftEn = 1'b0, TzShiftEn = 1'b0, RbShiftEn = 1'b0;
  logic       CtEnable, LvEnable, TzEnable, RbEnable;
  logic [4:0] TotalCoeff;
  logic [1:0] TrailingOnes;
  logic [3:0] TotalZeros;
  logic [4:0] NumShift;
  logic       ShiftEn, Busy, BlockDone, Error;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: the stage the next cycle is expected in (IDLE or ERR
  // between blocks) and the values the block should currently hold.
  int         cur = S_IDLE;
  logic [4:0] exp_tc = '0;
  logic [1:0] exp_t1 = '0;
  logic [3:0] exp_tz = '0;

  cavlc_block_sequencer #(.WATCHDOG_CYCLES(64), .WD_W(7)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .MaxNumCoeff(MaxNumCoeff),
    .CtDone(CtDone), .CtTotalCoeff(CtTotalCoeff), .CtTrailingOnes(CtTrailingOnes),
    .CtNumShift(CtNumShift), .CtShiftEn(CtShiftEn),
    .LvDone(LvDone), .LvNumShift(LvNumShift), .LvShiftEn(LvShiftEn),
    .TzDone(TzDone), .TzTotalZeros(TzTotalZeros),
    .TzNumShift(TzNumShift), .TzShiftEn(TzShiftEn),
    .RbDone(RbDone), .RbNumShift(RbNumShift), .RbShiftEn(RbShiftEn),
    .CtEnable(CtEnable), .LvEnable(LvEnable), .TzEnable(TzEnable), .RbEnable(RbEnable),
    .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes), .TotalZeros(TotalZeros),
    .NumShift(NumShift), .ShiftEn(ShiftEn),
    .Busy(Busy), .BlockDone(BlockDone), .Error(Error)
  );

  always #5 Clk = ~Clk;

  // One clock cycle: drive inputs on the falling edge, check every output
  // 1 ns later against what stage 'stg' should look like, then update the
  // expected latched values as of the coming rising edge.
  task automatic step(input int stg, input bit done, input bit start,
                      input bit abort, input bit rst,
                      input logic [4:0] tcv, input logic [1:0] t1v,
                      input logic [3:0] tzv, input logic [4:0] maxv,
                      input string name);
    logic [3:0]  dv;
    logic [4:0]  ns [4];
    logic [3:0]  se;
    logic [3:0]  en;
    logic [4:0]  ens;
    logic        ese;
    logic [23:0] got, expv;
    bit          active;
    active = (stg >= S_CT) && (stg <= S_RB);
    @(negedge Clk);
    dv = 4'($urandom);
    if (active) dv[stg-1] = done;
    for (int i = 0; i < 4; i++) ns[i] = 5'($urandom);
    se = 4'($urandom);
    Reset = rst; Start = start; Abort = abort; MaxNumCoeff = maxv;
    CtDone = dv[0]; LvDone = dv[1]; TzDone = dv[2]; RbDone = dv[3];
    CtTotalCoeff = tcv; CtTrailingOnes = t1v; TzTotalZeros = tzv;
    CtNumShift = ns[0]; CtShiftEn = se[0];
    LvNumShift = ns[1]; LvShiftEn = se[1];
    TzNumShift = ns[2]; TzShiftEn = se[2];
    RbNumShift = ns[3]; RbShiftEn = se[3];
    #1;
    en = '0; ens = '0; ese = 1'b0;
    if (active) begin
      en[stg-1] = 1'b1;
      ens = ns[stg-1];
      ese = se[stg-1];
    end
    expv = {en[0], en[1], en[2], en[3],
            (stg >= S_CT) && (stg <= S_DONE), stg == S_DONE, stg == S_ERR,
            ens, ese, exp_tc, exp_t1, exp_tz};
    got  = {CtEnable, LvEnable, TzEnable, RbEnable, Busy, BlockDone, Error,
            NumShift, ShiftEn, TotalCoeff, TrailingOnes, TotalZeros};
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s stage=%0d: got %b, expected %b (en4 busy done err ns5 se tc5 t1 tz4)",
               name, stg, got, expv);
    end
    if (rst) begin
      exp_tc = '0; exp_t1 = '0; exp_tz = '0;
    end else if (!abort) begin
      if (stg == S_CT && done) begin
        exp_tc = tcv;
        exp_t1 = t1v;
      end
      if (stg == S_TZ && done) exp_tz = tzv;
    end
  endtask

  // Run one block. d* is the cycle (0-based) within each stage on which its
  // Done is raised; 64 or more means never, letting the watchdog fire.
  // kill_kind: 0 none, 1 Abort (with Start), 2 Reset, at (kill_stg, kill_cnt).
  task automatic run_block(input logic [4:0] maxv, input logic [4:0] tc,
                           input logic [1:0] t1, input logic [3:0] tz,
                           input int dct, input int dlv, input int dtz, input int drb,
                           input int kill_stg, input int kill_cnt, input int kill_kind,
                           input string name);
    int         path[$];
    int         d[5];
    int         fin;
    int         s;
    bit         dn;
    logic [4:0] tcv;
    logic [1:0] t1v;
    logic [3:0] tzv;
    d[0] = 0; d[1] = dct; d[2] = dlv; d[3] = dtz; d[4] = drb;

    path.push_back(S_CT);
    if (tc == 0) fin = S_DONE;
    else if (int'(tc) > int'(maxv)) fin = S_ERR;
    else begin
      path.push_back(S_LV);
      if (tc == maxv) fin = S_DONE;
      else begin
        path.push_back(S_TZ);
        fin = S_DONE;
        if (tz != 0 && tc != 1) path.push_back(S_RB);
      end
    end

    step(cur, 1'b0, 1'b1, 1'b0, 1'b0, 5'($urandom), 2'($urandom), 4'($urandom), maxv, name);

    foreach (path[k]) begin
      s = path[k];
      for (int c = 0; c < WD; c++) begin
        dn = (c == d[s]);
        if (kill_kind != 0 && s == kill_stg && c == kill_cnt) begin
          step(s, 1'b0, 1'b1, kill_kind == 1, kill_kind == 2,
               5'($urandom), 2'($urandom), 4'($urandom), 5'($urandom), name);
          cur = S_IDLE;
          step(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 5'($urandom), 2'($urandom),
               4'($urandom), 5'($urandom), name);
          return;
        end
        tcv = (s == S_CT && dn) ? tc : 5'($urandom);
        t1v = (s == S_CT && dn) ? t1 : 2'($urandom);
        tzv = (s == S_TZ && dn) ? tz : 4'($urandom);
        step(s, dn, 1'($urandom), 1'b0, 1'b0, tcv, t1v, tzv, 5'($urandom), name);
        if (dn) break;
        if (c == WD - 1) begin
          step(S_ERR, 1'b0, 1'b0, 1'b0, 1'b0, 5'($urandom), 2'($urandom),
               4'($urandom), 5'($urandom), name);
          cur = S_ERR;
          return;
        end
      end
    end

    if (fin == S_ERR) begin
      step(S_ERR, 1'b0, 1'b0, 1'b0, 1'b0, 5'($urandom), 2'($urandom),
           4'($urandom), 5'($urandom), name);
      cur = S_ERR;
    end else begin
      step(S_DONE, 1'b0, 1'($urandom), 1'b0, 1'b0, 5'($urandom), 2'($urandom),
           4'($urandom), 5'($urandom), name);
      cur = S_IDLE;
    end
  endtask

  task automatic test_reset();
    logic [23:0] got;
    Reset = 1'b1; Start = 1'b1; CtDone = 1'b1; CtTotalCoeff = 5'd9;
    CtShiftEn = 1'b1; CtNumShift = 5'd7; MaxNumCoeff = 5'd16;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    got = {CtEnable, LvEnable, TzEnable, RbEnable, Busy, BlockDone, Error,
           NumShift, ShiftEn, TotalCoeff, TrailingOnes, TotalZeros};
    vectors++;
    if (got !== 24'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b, expected all zero", got);
    end
    cur = S_IDLE; exp_tc = '0; exp_t1 = '0; exp_tz = '0;
  endtask

  task automatic test_zero_coeff();
    run_block(5'd16, 5'd0, 2'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, "zero_coeff");
    run_block(5'd16, 5'd0, 2'd0, 4'd0, 3, 0, 0, 0, 0, 0, 0, "zero_coeff_slow");
  endtask

  task automatic test_full_block();
    run_block(5'd16, 5'd16, 2'd3, 4'd7, 1, 4, 0, 0, 0, 0, 0, "tc_eq_max16");
    run_block(5'd4, 5'd4, 2'd2, 4'd0, 0, 2, 0, 0, 0, 0, 0, "tc_eq_max4");
  endtask

  task automatic test_all_stages();
    run_block(5'd16, 5'd5, 2'd1, 4'd3, 2, 3, 1, 2, 0, 0, 0, "all_stages");
    run_block(5'd15, 5'd14, 2'd3, 4'd1, 0, 0, 0, 0, 0, 0, 0, "all_stages_15");
  endtask

  task automatic test_skip_rb();
    run_block(5'd16, 5'd5, 2'd0, 4'd0, 1, 1, 2, 0, 0, 0, 0, "skip_rb_tz0");
    run_block(5'd16, 5'd1, 2'd1, 4'd4, 0, 1, 1, 0, 0, 0, 0, "skip_rb_tc1");
  endtask

  task automatic test_watchdog();
    run_block(5'd16, 5'd5, 2'd1, 4'd3, 0, 200, 0, 0, 0, 0, 0, "wd_level");
    run_block(5'd16, 5'd3, 2'd0, 4'd2, 0, 0, 0, 1, 0, 0, 0, "start_from_err");
    run_block(5'd16, 5'd3, 2'd2, 4'd2, 63, 0, 63, 63, 0, 0, 0, "done_at_wd_limit");
    run_block(5'd16, 5'd6, 2'd0, 4'd5, 0, 0, 0, 100, 0, 0, 0, "wd_run_before");
  endtask

  task automatic test_abort();
    run_block(5'd16, 5'd5, 2'd1, 4'd3, 0, 10, 0, 0, S_LV, 2, 1, "abort_lv_with_start");
    run_block(5'd16, 5'd17, 2'd1, 4'd3, 0, 0, 0, 0, 0, 0, 0, "tc_over_max");
    step(S_ERR, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 4'd0, 5'd16, "abort_err");
    step(S_IDLE, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 4'd0, 5'd16, "abort_idle");
    step(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 4'd0, 5'd16, "idle_after_abort");
    cur = S_IDLE;
    run_block(5'd4, 5'd5, 2'd3, 4'd0, 1, 0, 0, 0, 0, 0, 0, "tc_over_max4");
    run_block(5'd15, 5'd9, 2'd0, 4'd4, 0, 0, 1, 5, S_RB, 3, 1, "abort_rb");
  endtask

  task automatic test_reset_mid_block();
    run_block(5'd16, 5'd7, 2'd2, 4'd5, 0, 0, 0, 6, S_RB, 2, 2, "reset_mid_block");
    run_block(5'd16, 5'd2, 2'd1, 4'd1, 0, 0, 0, 0, 0, 0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      run_block(5'd16, 5'(i * 2), 2'(i), 4'(i), 0, 0, 0, 0, 0, 0, 0, "back_to_back");
  endtask

  task automatic test_random();
    int         pick, kind;
    logic [4:0] maxv, tc;
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 2);
      maxv = (pick == 0) ? 5'd4 : (pick == 1) ? 5'd15 : 5'd16;
      tc   = 5'($urandom_range(0, int'(maxv) + 1));
      kind = ((i % 7) == 3) ? $urandom_range(1, 2) : 0;
      run_block(maxv, tc, 2'($urandom), 4'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(1, 4), $urandom_range(0, 2), kind, "random");
    end
  endtask

  initial begin
    test_reset();
    test_zero_coeff();
    test_full_block();
    test_all_stages();
    test_skip_rb();
    test_watchdog();
    test_abort();
    test_reset_mid_block();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
